jogo_memoria_param: RTL

Parametrised successor of the memory-game core. It stores a sequence of one-hot button codes and replays a growing prefix of that sequence on the LEDs each round. It then checks the player's button presses against that prefix and finishes in a won, lost or timed-out state. It is the top-level game datapath plus FSM; the board wrapper adds only debouncing and 7-segment decoding.

---
 rtl/jogo_memoria_param.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/jogo_memoria_param.sv
// Memory-game core: stores a one-hot sequence, replays a growing prefix on the LEDs and checks the player's moves.
// Optional move timer and TIMEOUT state are built only when JOGO_TIMEOUT_EN is defined.
module jogo_memoria_param #(
    parameter int N_BOTOES       = 4,
    parameter int N_JOGADAS      = 16,
    parameter int T_MOSTRA       = 500,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int W_END         = (N_JOGADAS > 1) ? $clog2(N_JOGADAS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                carga,
    input  logic [W_END-1:0]    carga_end,
    input  logic [N_BOTOES-1:0] carga_dado,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [3:0]          db_estado,
    output logic [W_END-1:0]    db_rodada,
    output logic [W_END-1:0]    db_jogada
);

    localparam int W_MOSTRA = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;

    typedef enum logic [3:0] {
        ST_INICIAL      = 4'd0,
        ST_PREPARA      = 4'd1,
        ST_MOSTRA_LIGA  = 4'd2,
        ST_MOSTRA_APAGA = 4'd3,
        ST_ESPERA       = 4'd4,
        ST_REGISTRA     = 4'd5,
        ST_COMPARA      = 4'd6,
        ST_PROX_JOGADA  = 4'd7,
        ST_PROX_RODADA  = 4'd8,
        ST_GANHOU       = 4'd10,
        ST_PERDEU       = 4'd11,
        ST_TIMEOUT      = 4'd12
    } estado_t;

    estado_t             state_r;
    estado_t             state_nx_s;
    logic [N_BOTOES-1:0] mem_r [N_JOGADAS];
    logic [N_BOTOES-1:0] botoes_r;
    logic [N_BOTOES-1:0] botoes_ant_r;
    logic [N_BOTOES-1:0] codigo_r;
    logic [W_END-1:0]    rodada_r;
    logic [W_END-1:0]    jogada_r;
    logic [W_END-1:0]    k_r;
    logic [W_END-1:0]    k_nx_s;
    logic [W_MOSTRA-1:0] cnt_mostra_r;
    logic                fim_mostra_s;
    logic                fim_espera_s;
    logic                press_s;
    logic                escrita_ok_s;
    logic [N_BOTOES-1:0] leds_nx_s;
    logic                pronto_nx_s;
    logic                ganhou_nx_s;
    logic                perdeu_nx_s;
    logic                timeout_nx_s;
    logic [N_BOTOES-1:0] leds_r;
    logic                pronto_r;
    logic                ganhou_r;
    logic                perdeu_r;

    function automatic logic one_hot(input logic [N_BOTOES-1:0] code);
        return (code != '0) && ((code & (code - 1'b1)) == '0);
    endfunction

    function automatic logic [N_BOTOES-1:0] codigo_padrao(input int idx);
        logic [N_BOTOES-1:0] v;
        v = {{(N_BOTOES-1){1'b0}}, 1'b1} << (idx % N_BOTOES);
        return v;
    endfunction

    assign fim_mostra_s = (cnt_mostra_r == W_MOSTRA'(T_MOSTRA - 1));
    assign press_s      = (|botoes_r) && !(|botoes_ant_r);
    assign escrita_ok_s = (state_r == ST_INICIAL) || (state_r == ST_GANHOU) ||
                          (state_r == ST_PERDEU)  || (state_r == ST_TIMEOUT);

`ifdef JOGO_TIMEOUT_EN
    localparam int W_TMO = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    logic [W_TMO-1:0] cnt_espera_r;
    logic             timeout_r;

    assign fim_espera_s = (cnt_espera_r == W_TMO'(TIMEOUT_CICLOS - 1));
    assign timeout      = timeout_r;

    // Move timer: runs only while waiting for a press, restarts on every other state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_espera_r <= '0;
        end else if (state_r == ST_ESPERA) begin
            cnt_espera_r <= cnt_espera_r + 1'b1;
        end else begin
            cnt_espera_r <= '0;
        end
    end

    // Registered timeout flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_nx_s;
        end
    end
`else
    assign fim_espera_s = 1'b0;
    assign timeout      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_INICIAL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_INICIAL, ST_GANHOU, ST_PERDEU, ST_TIMEOUT: begin
                if (jogar) begin
                    state_nx_s = ST_PREPARA;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_PREPARA:      state_nx_s = ST_MOSTRA_LIGA;
            ST_MOSTRA_LIGA: begin
                if (fim_mostra_s) begin
                    state_nx_s = ST_MOSTRA_APAGA;
                end else begin
                    state_nx_s = ST_MOSTRA_LIGA;
                end
            end
            ST_MOSTRA_APAGA: begin
                if (!fim_mostra_s) begin
                    state_nx_s = ST_MOSTRA_APAGA;
                end else if (k_r == rodada_r) begin
                    state_nx_s = ST_ESPERA;
                end else begin
                    state_nx_s = ST_MOSTRA_LIGA;
                end
            end
            ST_ESPERA: begin
                // A press in the last timer cycle still counts as a move.
                if (press_s) begin
                    state_nx_s = ST_REGISTRA;
                end else if (fim_espera_s) begin
                    state_nx_s = ST_TIMEOUT;
                end else begin
                    state_nx_s = ST_ESPERA;
                end
            end
            ST_REGISTRA:     state_nx_s = ST_COMPARA;
            ST_COMPARA: begin
                if (!one_hot(codigo_r)) begin
                    state_nx_s = ST_PERDEU;
                end else if (codigo_r != mem_r[jogada_r]) begin
                    state_nx_s = ST_PERDEU;
                end else if (jogada_r != rodada_r) begin
                    state_nx_s = ST_PROX_JOGADA;
                end else if (rodada_r == W_END'(N_JOGADAS - 1)) begin
                    state_nx_s = ST_GANHOU;
                end else begin
                    state_nx_s = ST_PROX_RODADA;
                end
            end
            ST_PROX_JOGADA:  state_nx_s = ST_ESPERA;
            ST_PROX_RODADA:  state_nx_s = ST_MOSTRA_LIGA;
            default:         state_nx_s = ST_INICIAL;
        endcase
    end

    // Replay index: restarts at each round, advances after every dark phase.
    always_comb begin
        k_nx_s = k_r;
        case (state_r)
            ST_PREPARA, ST_PROX_RODADA: k_nx_s = '0;
            ST_MOSTRA_APAGA: begin
                if (fim_mostra_s && (k_r != rodada_r)) begin
                    k_nx_s = k_r + 1'b1;
                end else begin
                    k_nx_s = k_r;
                end
            end
            default:                    k_nx_s = k_r;
        endcase
    end

    // Output values computed from the next state so the registered outputs line up with db_estado.
    always_comb begin
        leds_nx_s    = '0;
        pronto_nx_s  = 1'b0;
        ganhou_nx_s  = 1'b0;
        perdeu_nx_s  = 1'b0;
        timeout_nx_s = 1'b0;
        case (state_nx_s)
            ST_MOSTRA_LIGA: leds_nx_s = mem_r[k_nx_s];
            ST_ESPERA:      leds_nx_s = botoes;
            ST_GANHOU: begin
                pronto_nx_s = 1'b1;
                ganhou_nx_s = 1'b1;
            end
            ST_PERDEU: begin
                pronto_nx_s = 1'b1;
                perdeu_nx_s = 1'b1;
            end
            ST_TIMEOUT: begin
                pronto_nx_s  = 1'b1;
                timeout_nx_s = 1'b1;
            end
            default:        leds_nx_s = '0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            leds_r   <= '0;
            pronto_r <= 1'b0;
            ganhou_r <= 1'b0;
            perdeu_r <= 1'b0;
        end else begin
            leds_r   <= leds_nx_s;
            pronto_r <= pronto_nx_s;
            ganhou_r <= ganhou_nx_s;
            perdeu_r <= perdeu_nx_s;
        end
    end

    // Datapath: button pipeline, replay timing and round/move counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            botoes_r     <= '0;
            botoes_ant_r <= '0;
            codigo_r     <= '0;
            rodada_r     <= '0;
            jogada_r     <= '0;
            k_r          <= '0;
            cnt_mostra_r <= '0;
        end else begin
            botoes_r     <= botoes;
            botoes_ant_r <= botoes_r;
            k_r          <= k_nx_s;
            if (state_nx_s == ST_PREPARA) begin
                rodada_r <= '0;
                jogada_r <= '0;
                codigo_r <= '0;
            end else if (state_r == ST_PROX_JOGADA) begin
                jogada_r <= jogada_r + 1'b1;
            end else if (state_r == ST_PROX_RODADA) begin
                rodada_r <= rodada_r + 1'b1;
                jogada_r <= '0;
            end else if (state_r == ST_REGISTRA) begin
                codigo_r <= botoes_r;
            end
            if (((state_r == ST_MOSTRA_LIGA) || (state_r == ST_MOSTRA_APAGA)) && !fim_mostra_s) begin
                cnt_mostra_r <= cnt_mostra_r + 1'b1;
            end else begin
                cnt_mostra_r <= '0;
            end
        end
    end

    // Sequence memory: default one-hot walk on reset, writable only while idle or finished.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_JOGADAS; i++) begin
                mem_r[i] <= codigo_padrao(i);
            end
        end else if (carga && escrita_ok_s && (int'(carga_end) < N_JOGADAS)) begin
            mem_r[carga_end] <= carga_dado;
        end
    end

    assign leds      = leds_r;
    assign pronto    = pronto_r;
    assign ganhou    = ganhou_r;
    assign perdeu    = perdeu_r;
    assign db_estado = state_r;
    assign db_rodada = rodada_r;
    assign db_jogada = jogada_r;

endmodule
